stopwatch_display: RTL

Display back-end for the stopwatch: consumes the binary minute, second and centisecond counts from the stopwatch counter chain and drives a six-digit multiplexed seven-segment display as MM.SS.CC. It samples the counts on request, converts each field to two BCD digits with a fixed-latency sequential double-dabble, and holds the result in display registers. A free-running prescaler scans one digit at a time. A lap `hold` input freezes the shown value while the counters keep running upstream.

---
 rtl/stopwatch_display_if.sv | 24 ++
 rtl/stopwatch_display.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_display_if.sv
// Signal bundle between the stopwatch counter chain / display pins and the
// display back-end. The master drives counts and requests; the slave is the
// display back-end that drives the LED pins and busy.
interface stopwatch_display_if;
  logic [6:0] min;
  logic [6:0] sec;
  logic [7:0] centi;
  logic       sample;
  logic       hold;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       busy;

  modport master (
    output min, sec, centi, sample, hold,
    input  seg, dp, an, busy
  );

  modport slave (
    input  min, sec, centi, sample, hold,
    output seg, dp, an, busy
  );
endinterface

// File: rtl/stopwatch_display.sv
// Stopwatch display back-end: captures clamped min/sec/centi counts, converts
// each to two BCD digits with a 7-step sequential double-dabble, and scans the
// result onto a six-digit multiplexed seven-segment display as MM.SS.CC.
module stopwatch_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input logic             clk,
  input logic             reset,
  stopwatch_display_if.slave bus
);

  localparam int unsigned PresW = $clog2(SCAN_DIV);
  localparam logic [PresW-1:0] PresMax = PresW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e      state_q, state_d;
  logic        capture, commit;
  logic        busy_q;
  logic [2:0]  step_q;
  logic [6:0]  bin_min_q, bin_sec_q, bin_centi_q;
  logic [7:0]  bcd_min_q, bcd_sec_q, bcd_centi_q;
  logic [23:0] disp_q;
  logic [PresW-1:0] presc_q;
  logic [2:0]  digit_q;
  logic [3:0]  nib;
  logic [6:0]  seg_c;
  logic [5:0]  an_c;
  logic        dp_c;

  // Fields above 99 saturate so every conversion result is two valid digits.
  function automatic logic [6:0] clamp99(input logic [7:0] v);
    return (v > 8'd99) ? 7'd99 : v[6:0];
  endfunction

  // One double-dabble step: add-3 correction, then shift {bcd, bin} left by one.
  function automatic logic [14:0] dd_step(input logic [7:0] bcd, input logic [6:0] bin);
    logic [7:0] adj;
    adj[3:0] = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    adj[7:4] = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
    return {adj[6:0], bin, 1'b0};
  endfunction

  // FSM state register and registered busy flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  // Next-state logic; hold blocks new captures and suppresses the commit.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.sample && !bus.hold) begin
          state_d = StShift;
          capture = 1'b1;
        end
      end
      StShift: begin
        if (step_q == 3'd6) state_d = StCommit;
      end
      StCommit: begin
        state_d = StIdle;
        commit  = !bus.hold;
      end
      default: state_d = StIdle;
    endcase
  end

  // Conversion datapath: load clamped fields, then shift all three in parallel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      step_q      <= '0;
      bin_min_q   <= '0;
      bin_sec_q   <= '0;
      bin_centi_q <= '0;
      bcd_min_q   <= '0;
      bcd_sec_q   <= '0;
      bcd_centi_q <= '0;
    end else if (capture) begin
      step_q      <= '0;
      bin_min_q   <= clamp99({1'b0, bus.min});
      bin_sec_q   <= clamp99({1'b0, bus.sec});
      bin_centi_q <= clamp99(bus.centi);
      bcd_min_q   <= '0;
      bcd_sec_q   <= '0;
      bcd_centi_q <= '0;
    end else if (state_q == StShift) begin
      step_q                     <= step_q + 3'd1;
      {bcd_min_q, bin_min_q}     <= dd_step(bcd_min_q, bin_min_q);
      {bcd_sec_q, bin_sec_q}     <= dd_step(bcd_sec_q, bin_sec_q);
      {bcd_centi_q, bin_centi_q} <= dd_step(bcd_centi_q, bin_centi_q);
    end
  end

  // Display registers, nibble 5 = minute tens down to nibble 0 = centi units.
  always_ff @(posedge clk) begin
    if (!reset) begin
      disp_q <= '0;
    end else if (commit) begin
      disp_q <= {bcd_min_q, bcd_sec_q, bcd_centi_q};
    end
  end

  // Free-running scan prescaler; each wrap advances to the next digit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      digit_q <= '0;
    end else if (presc_q == PresMax) begin
      presc_q <= '0;
      digit_q <= (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
    end else begin
      presc_q <= presc_q + PresW'(1);
    end
  end

  // Digit select: enable, nibble and decimal point for the current digit.
  always_comb begin
    nib  = 4'd0;
    an_c = 6'b111111;
    unique case (digit_q)
      3'd0: begin nib = disp_q[3:0];   an_c = 6'b111110; end
      3'd1: begin nib = disp_q[7:4];   an_c = 6'b111101; end
      3'd2: begin nib = disp_q[11:8];  an_c = 6'b111011; end
      3'd3: begin nib = disp_q[15:12]; an_c = 6'b110111; end
      3'd4: begin nib = disp_q[19:16]; an_c = 6'b101111; end
      3'd5: begin nib = disp_q[23:20]; an_c = 6'b011111; end
      default: begin nib = 4'd0; an_c = 6'b111111; end
    endcase
    // Points after the minute and second units give MM.SS.CC.
    dp_c = !((digit_q == 3'd2) || (digit_q == 3'd4));
  end

  // Active-low seven-segment decode {g,f,e,d,c,b,a}; non-BCD blanks.
  always_comb begin
    seg_c = 7'b1111111;
    unique case (nib)
      4'd0: seg_c = 7'b1000000;
      4'd1: seg_c = 7'b1111001;
      4'd2: seg_c = 7'b0100100;
      4'd3: seg_c = 7'b0110000;
      4'd4: seg_c = 7'b0011001;
      4'd5: seg_c = 7'b0010010;
      4'd6: seg_c = 7'b0000010;
      4'd7: seg_c = 7'b1111000;
      4'd8: seg_c = 7'b0000000;
      4'd9: seg_c = 7'b0010000;
      default: seg_c = 7'b1111111;
    endcase
  end

  assign bus.seg  = seg_c;
  assign bus.an   = an_c;
  assign bus.dp   = dp_c;
  assign bus.busy = busy_q;

endmodule
